// File: rtl/cpu_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_controller
//  Description : Single-port CPU memory controller. A request (address, data,
//                direction) is captured in IDLE, held through LATENCY wait
//                cycles, then serviced in ACK. Read data and a one-cycle
//                ReadOK/WriteOK pulse appear the cycle after ACK.
//                Optional feature macro: CPU_MEM_CONTROLLER_RANGE_CHECK_EN
//                (out-of-range word indices read 32'hDEADBEEF and discard
//                writes; without it indices wrap modulo DEPTH_WORDS).
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_mem_controller #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] AddressBus,
  input  logic [31:0] DataWriteBus,
  input  logic        WriteAssert,
  output logic [31:0] DataReadBus,
  output logic        ReadOK,
  output logic        WriteOK
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd1;
  localparam logic [1:0]  ST_ACK    = 2'd2;
  localparam logic [3:0]  WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] OOR_DATA  = 32'hDEADBEEF;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_data;
  logic             cap_write;
  logic             cap_oor;
  logic             addr_oor;
  logic             rd_fire;
  logic             wr_fire;
  logic             mem_we;
  logic             unused_addr_bits;

  // Backing storage; deliberately has no reset so contents survive Reset_n.
  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane bits are never used, and above-index bits only feed the range
  // check when it is built in.
  assign unused_addr_bits = ^{AddressBus[1:0], (AddressBus[31:2] >> IDX_W)};

`ifdef CPU_MEM_CONTROLLER_RANGE_CHECK_EN
  // Full 30-bit word index compared against the storage size.
  assign addr_oor = ({2'b00, AddressBus[31:2]} >= 32'(DEPTH_WORDS));
`else
  // Indices simply wrap: only the low IDX_W index bits address storage.
  assign addr_oor = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE always leaves after one capture edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = (LATENCY > 0) ? ST_WAIT : ST_ACK;
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: what the ACK cycle does for the captured request.
  always_comb begin
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    mem_we  = 1'b0;
    if (state == ST_ACK) begin
      rd_fire = !cap_write;
      wr_fire = cap_write;
      mem_we  = cap_write && !cap_oor;
    end
  end

  // Wait counter: runs only in WAIT, parked at zero elsewhere.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= 4'd0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Request capture: sampled on every IDLE edge, frozen through WAIT/ACK.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cap_idx   <= '0;
      cap_data  <= 32'd0;
      cap_write <= 1'b0;
      cap_oor   <= 1'b0;
    end else if (state == ST_IDLE) begin
      cap_idx   <= AddressBus[IDX_W+1:2];
      cap_data  <= DataWriteBus;
      cap_write <= WriteAssert;
      cap_oor   <= addr_oor;
    end
  end

  // Storage write at the end of a write ACK cycle.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[cap_idx] <= cap_data;
    end
  end

  // Registered acknowledges and read data; read data holds between reads.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ReadOK      <= 1'b0;
      WriteOK     <= 1'b0;
      DataReadBus <= 32'd0;
    end else begin
      ReadOK  <= rd_fire;
      WriteOK <= wr_fire;
      if (rd_fire) begin
        DataReadBus <= cap_oor ? OOR_DATA : mem[cap_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mem_controller
//  Description : Scoreboard bench. A driver issues requests and pushes the
//                expected acknowledge into a queue; a monitor pops and compares
//                on every ReadOK/WriteOK. A second LATENCY=0 instance checks
//                back-to-back read pacing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_mem_controller;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        Clock;
  logic        Reset_n;
  logic [31:0] AddressBus;
  logic [31:0] DataWriteBus;
  logic        WriteAssert;
  logic [31:0] DataReadBus;
  logic        ReadOK;
  logic        WriteOK;

  logic        rst0_n;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        wr0;
  logic [31:0] rdata0;
  logic        rok0;
  logic        wok0;
  bit          done0;

  int checks;
  int passes;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rd;
  logic        prev_ack;

  cpu_mem_controller #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .AddressBus  (AddressBus),
    .DataWriteBus(DataWriteBus),
    .WriteAssert (WriteAssert),
    .DataReadBus (DataReadBus),
    .ReadOK      (ReadOK),
    .WriteOK     (WriteOK)
  );

  cpu_mem_controller #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
    .Clock       (Clock),
    .Reset_n     (rst0_n),
    .AddressBus  (addr0),
    .DataWriteBus(wdata0),
    .WriteAssert (wr0),
    .DataReadBus (rdata0),
    .ReadOK      (rok0),
    .WriteOK     (wok0)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: word = byte address / 4; wrap or range-check by rule.
  function automatic logic [31:0] model_access(input logic [31:0] addr,
                                               input logic wr,
                                               input logic [31:0] data);
    int unsigned word;
    int unsigned idx;
    word = addr / 4;
`ifdef CPU_MEM_CONTROLLER_RANGE_CHECK_EN
    if (word >= DEPTH) return 32'hDEADBEEF;
`endif
    idx = word % DEPTH;
    if (wr) model_mem[idx] = data;
    return model_mem[idx];
  endfunction

  // Wait for the acknowledge, scrambling inputs while the DUT is busy.
  task automatic wait_ack();
    int n;
    bit got;
    got = 0;
    for (n = 1; n <= LAT + 6; n++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (ReadOK || WriteOK) begin
        got = 1;
        break;
      end
      AddressBus   = $urandom;
      DataWriteBus = $urandom;
      WriteAssert  = 1'($urandom_range(0, 1));
    end
    check("ack_latency", got ? n : -1, LAT + 2);
  endtask

  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] data);
    exp_t e;
    AddressBus   = addr;
    WriteAssert  = wr;
    DataWriteBus = data;
    e.is_wr = wr;
    e.data  = model_access(addr, wr, data);
    exp_q.push_back(e);
    wait_ack();
  endtask

  // Monitor: pops the scoreboard on every acknowledge of the main instance.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset_n) begin
      last_rd  = 32'd0;
      prev_ack = 1'b0;
    end else begin
      if (ReadOK || WriteOK) begin
        check("single_ack_kind", ReadOK && WriteOK, 0);
        check("ack_one_cycle", prev_ack, 0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ack: ReadOK=%0b WriteOK=%0b, no request pending",
                   ReadOK, WriteOK);
        end else begin
          e = exp_q.pop_front();
          check("ack_kind_is_write", WriteOK, e.is_wr);
          if (ReadOK) begin
            check("read_data", DataReadBus, e.data);
            last_rd = e.data;
          end else begin
            check("rdata_held_over_write", DataReadBus, last_rd);
          end
        end
      end
      prev_ack = ReadOK || WriteOK;
    end
  end

  // LATENCY=0 instance: write word 0, then read continuously.
  initial begin
    int n;
    bit got;
    rst0_n = 1'b0;
    addr0  = 32'd0;
    wdata0 = 32'hCAFEF00D;
    wr0    = 1'b1;
    repeat (2) @(negedge Clock);
    rst0_n = 1'b1;
    got = 0;
    for (n = 1; n <= 6; n++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (wok0) begin
        got = 1;
        break;
      end
    end
    check("lat0_write_latency", got ? n : -1, 2);
    wr0 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      check("lat0_readok_pattern", rok0, (k % 2) == 0);
      check("lat0_no_writeok", wok0, 0);
      if ((k % 2) == 0) check("lat0_read_data", rdata0, 32'hCAFEF00D);
    end
    done0 = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    checks       = 0;
    passes       = 0;
    Reset_n      = 1'b0;
    AddressBus   = 32'd0;
    DataWriteBus = 32'd0;
    WriteAssert  = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_readok", ReadOK, 0);
    check("reset_writeok", WriteOK, 0);
    check("reset_rdata", DataReadBus, 0);
    Reset_n = 1'b1;

    // Fill every word so later reads have a known model value.
    for (int i = 0; i < DEPTH; i++) issue(32'(i * 4), 1'b1, $urandom);

    // Basic write then read.
    issue(32'h10, 1'b1, 32'h12345678);
    issue(32'h10, 1'b0, 32'h0);
    // Misaligned access hits the containing word.
    issue(32'h43, 1'b1, 32'hA5A5A5A5);
    issue(32'h40, 1'b0, 32'h0);
    // Beyond storage: wraps to word 0 or reads DEADBEEF.
    issue(32'h1000, 1'b0, 32'h0);
    issue(32'h1000, 1'b1, 32'h0BADF00D);
    issue(32'h0, 1'b0, 32'h0);

    // Reset during a write WAIT to 0x20.
    issue(32'h20, 1'b1, 32'h11112222);
    issue(32'h20, 1'b0, 32'h0);
    AddressBus   = 32'h20;
    WriteAssert  = 1'b1;
    DataWriteBus = 32'h99999999;
    @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check("midreset_rdata", DataReadBus, 0);
    check("midreset_readok", ReadOK, 0);
    check("midreset_writeok", WriteOK, 0);
    repeat (3) begin
      @(negedge Clock);
      check("midreset_no_ack", ReadOK || WriteOK, 0);
    end
    Reset_n = 1'b1;
    issue(32'h20, 1'b0, 32'h0);

    // Randomized traffic, mostly in range, occasionally anywhere.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, DEPTH * 4 - 1));
      else a = $urandom;
      issue(a, 1'($urandom_range(0, 1)), $urandom);
    end

    for (int w = 0; w < 200 && !done0; w++) @(negedge Clock);
    check("lat0_finished", done0, 1);
    repeat (2) @(negedge Clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
